controller: RTL and testbench
=============================

// Module: controller
// PURPOSE
// Multicycle control FSM of the 12-bit-instruction CPU. Sits in the control unit beside the PC/IR registers and
// decodes opCode (IR[11:9]). Sequences fetch/decode/execute and drives register-file, data-memory, display and ALU
// strobes plus the operand-select muxes. Moore FSM; no datapath.
// PARAMETERS
// none (encodings below are fixed)
// PORTS
// clk         in   1  system clock, rising edge
// reset       in   1  asynchronous, active-low reset (0 = reset)
// opCode      in   3  IR[11:9] of the currently latched instruction
// RF_we       out  1  register-file write enable
// M_we        out  1  data-memory write enable
// M_re        out  1  data-memory read enable
// D_re        out  1  display-register read/latch enable
// ALU_opcode  out  3  ALU function: 000 ADD, 001 SUB, 010 AND, 011 OR
// inSRC       out  1  1: r1=IR[2:0], r2=IR[5:3] (ALU); 0: r1=r2=IR[6:4]
// rwSRC       out  1  1: rw=IR[6:4] (LOAD); 0: rw=IR[8:6] (ALU)
// PCEn        out  1  PC increment enable
// IREn        out  1  instruction-register load enable
// BEHAVIOUR
// - Opcodes: 000 LOAD RF[IR6:4]<=M[IR3:0]; 001 STORE M[IR3:0]<=RF[IR6:4]; 010 DISP display<=RF[IR6:4];
//   011 NOP; 100 ADD, 101 SUB, 110 AND, 111 OR: RF[IR8:6]<=RF[IR5:3] op RF[IR2:0].
// - States: FETCH, DECODE, EXEC, WB. Registered 2-bit state; outputs decoded combinationally from state+opCode.
// - reset=0 (any time, async): state<=FETCH immediately; while reset=0 ALL outputs forced to 0.
// - First rising edge with reset=1 is spent in FETCH.
// - FETCH: IREn=1, PCEn=1 (PC and IR update on same edge); -> DECODE.
// - DECODE: all strobes 0; opCode now valid; -> EXEC.
// - EXEC by opCode:
//   LOAD : M_re=1, rwSRC=1; -> WB.
//   STORE: M_we=1, inSRC=0; -> FETCH.
//   DISP : D_re=1, inSRC=0; -> FETCH.
//   NOP  : no strobes; -> FETCH.
//   ALU  : RF_we=1, inSRC=1, rwSRC=0, ALU_opcode={1'b0,opCode[1:0]}; -> FETCH.
// - WB (LOAD only): M_re=1, RF_we=1, rwSRC=1; -> FETCH.
// - Defaults whenever not stated: all enables 0, ALU_opcode=000, inSRC=0, rwSRC=0.
// - Latency: 3 cycles per instruction, LOAD 4. Exactly one cycle of PCEn and IREn per instruction.
// - RF_we, M_we, D_re are one-cycle pulses; never more than one of M_we/RF_we/D_re in EXEC.
// - Illegal state encoding (unused 2'b11 if WB is not encoded there) recovers to FETCH next edge.
// - Reset mid-instruction aborts it; no partial strobe occurs after reset release before a new FETCH.
// - opCode changes outside DECODE/EXEC/WB are ignored.
// TESTING
// - reset=0 mid-EXEC of ADD -> all outputs 0 same cycle (async); release -> FETCH with IREn=PCEn=1.
// - opCode=100 -> FETCH,DECODE,EXEC: EXEC has RF_we=1,inSRC=1,rwSRC=0,ALU_opcode=000; back to FETCH on cycle 4.
// - opCode=000 -> EXEC M_re=1,RF_we=0; WB M_re=1,RF_we=1,rwSRC=1; next FETCH after 4 cycles total.
// - opCode=001 -> EXEC M_we=1 one cycle, RF_we=0, inSRC=0; opCode=010 -> D_re=1 one cycle only.
// - opCodes 101/110/111 -> ALU_opcode 001/010/011 in EXEC; opCode=011 -> no strobes, 3-cycle loop.
// - Run 4 mixed instructions back-to-back -> exactly 4 PCEn pulses; assert no cycle with M_we&RF_we.

Source files
------------

// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller
// Multicycle control FSM for the 12-bit-instruction CPU. Steps every
// instruction through FETCH -> DECODE -> EXEC (-> WB for LOAD only) and
// drives the register-file, data-memory, display and ALU strobes plus the
// operand-select muxes. This is a Moore machine and holds no datapath.
//
// Ports
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous, active-low reset (0 = reset)
//   opCode      in   3  IR[11:9] of the currently latched instruction
//   RF_we       out  1  register-file write enable
//   M_we        out  1  data-memory write enable
//   M_re        out  1  data-memory read enable
//   D_re        out  1  display-register latch enable
//   ALU_opcode  out  3  000 ADD, 001 SUB, 010 AND, 011 OR
//   inSRC       out  1  1: r1=IR[2:0], r2=IR[5:3]; 0: r1=r2=IR[6:4]
//   rwSRC       out  1  1: rw=IR[6:4]; 0: rw=IR[8:6]
//   PCEn        out  1  PC increment enable
//   IREn        out  1  instruction-register load enable
//   dbg_state   out  2  current FSM state (00 FETCH, 01 DECODE, 10 EXEC, 11 WB)
//
// Handshake: this block has no valid/ready interfaces. Every strobe is a
// single-cycle level, qualified only by the current state, and is sampled by
// the datapath on the rising clock edge that ends that state.
// -----------------------------------------------------------------------------
module controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opCode,
   output logic       RF_we,
   output logic       M_we,
   output logic       M_re,
   output logic       D_re,
   output logic [2:0] ALU_opcode,
   output logic       inSRC,
   output logic       rwSRC,
   output logic       PCEn,
   output logic       IREn,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'b00,
      S_DECODE = 2'b01,
      S_EXEC   = 2'b10,
      S_WB     = 2'b11
   } state_t;

   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_STORE = 3'b001;
   localparam logic [2:0] OP_DISP  = 3'b010;
   localparam logic [2:0] OP_NOP   = 3'b011;

   state_t state_q, state_d;

   // Next-state logic. opCode is only looked at in EXEC, so changes while
   // fetching or decoding cannot disturb the sequence.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC;
         S_EXEC:   state_d = (opCode == OP_LOAD) ? S_WB : S_FETCH;
         S_WB:     state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Output decode. Reset gates every output directly so that asserting
   // reset silences all strobes in the same cycle, without waiting for a
   // clock edge.
   always_comb begin
      RF_we      = 1'b0;
      M_we       = 1'b0;
      M_re       = 1'b0;
      D_re       = 1'b0;
      ALU_opcode = 3'b000;
      inSRC      = 1'b0;
      rwSRC      = 1'b0;
      PCEn       = 1'b0;
      IREn       = 1'b0;
      if (reset) begin
         case (state_q)
            S_FETCH: begin
               // PC and IR advance on the same edge.
               IREn = 1'b1;
               PCEn = 1'b1;
            end
            S_DECODE: ;
            S_EXEC: begin
               case (opCode)
                  OP_LOAD: begin
                     M_re  = 1'b1;
                     rwSRC = 1'b1;
                  end
                  OP_STORE: M_we = 1'b1;
                  OP_DISP:  D_re = 1'b1;
                  OP_NOP:   ;
                  default: begin
                     // opCode[2] set: ALU op, function taken from the low bits.
                     RF_we      = 1'b1;
                     inSRC      = 1'b1;
                     ALU_opcode = {1'b0, opCode[1:0]};
                  end
               endcase
            end
            S_WB: begin
               // LOAD keeps the memory read asserted while the register
               // file captures the returned data.
               M_re  = 1'b1;
               RF_we = 1'b1;
               rwSRC = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_controller.sv
// Directed testbench for controller. Inputs change on the falling edge and
// outputs are sampled on the falling edge (or a few ns after an async event).
module tb_controller;

   logic       clk;
   logic       reset;
   logic [2:0] opCode;
   logic       RF_we, M_we, M_re, D_re, inSRC, rwSRC, PCEn, IREn;
   logic [2:0] ALU_opcode;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int pcen_cnt = 0;

   // Output vector order: RF_we M_we M_re D_re ALU[2:0] inSRC rwSRC PCEn IREn
   logic [10:0] outs;
   assign outs = {RF_we, M_we, M_re, D_re, ALU_opcode, inSRC, rwSRC, PCEn, IREn};

   localparam logic [10:0] O_NONE    = 11'b0000_000_0_0_0_0;
   localparam logic [10:0] O_FETCH   = 11'b0000_000_0_0_1_1;
   localparam logic [10:0] O_LOAD_EX = 11'b0010_000_0_1_0_0;
   localparam logic [10:0] O_LOAD_WB = 11'b1010_000_0_1_0_0;
   localparam logic [10:0] O_STORE   = 11'b0100_000_0_0_0_0;
   localparam logic [10:0] O_DISP    = 11'b0001_000_0_0_0_0;
   localparam logic [10:0] O_ADD     = 11'b1000_000_1_0_0_0;
   localparam logic [10:0] O_SUB     = 11'b1000_001_1_0_0_0;
   localparam logic [10:0] O_AND     = 11'b1000_010_1_0_0_0;
   localparam logic [10:0] O_OR      = 11'b1000_011_1_0_0_0;

   localparam logic [1:0] ST_FETCH  = 2'b00;
   localparam logic [1:0] ST_DECODE = 2'b01;
   localparam logic [1:0] ST_EXEC   = 2'b10;
   localparam logic [1:0] ST_WB     = 2'b11;

   controller dut (
      .clk        (clk),
      .reset      (reset),
      .opCode     (opCode),
      .RF_we      (RF_we),
      .M_we       (M_we),
      .M_re       (M_re),
      .D_re       (D_re),
      .ALU_opcode (ALU_opcode),
      .inSRC      (inSRC),
      .rwSRC      (rwSRC),
      .PCEn       (PCEn),
      .IREn       (IREn),
      .dbg_state  (dbg_state)
   );

   // Clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #20000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // PC-increment pulse counter
   always @(posedge clk) if (reset && PCEn) pcen_cnt++;

   // Strobe exclusivity monitor: at most one of M_we/RF_we/D_re per cycle.
   always @(negedge clk) begin
      if (reset) begin
         n_checks++;
         assert ($countones({M_we, RF_we, D_re}) <= 1)
         else begin
            n_fail++;
            $error("FAIL strobe_excl: observed M_we=%b RF_we=%b D_re=%b expected at most one",
                   M_we, RF_we, D_re);
         end
      end
   end

   task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Runs one instruction from a FETCH falling edge to the next FETCH
   // falling edge, checking state and outputs in every cycle.
   task automatic run_instr(input string name, input logic [2:0] op,
                            input logic [10:0] exp_exec, input logic is_load);
      // opCode is irrelevant in FETCH; drive a wrong value first.
      opCode = ~op;
      #1;
      chk({name, "_fetch_out"}, outs, O_FETCH);
      chk({name, "_fetch_st"}, {9'b0, dbg_state}, {9'b0, ST_FETCH});
      opCode = op;
      tick();
      chk({name, "_dec_out"}, outs, O_NONE);
      chk({name, "_dec_st"}, {9'b0, dbg_state}, {9'b0, ST_DECODE});
      tick();
      chk({name, "_exec_out"}, outs, exp_exec);
      chk({name, "_exec_st"}, {9'b0, dbg_state}, {9'b0, ST_EXEC});
      if (is_load) begin
         tick();
         chk({name, "_wb_out"}, outs, O_LOAD_WB);
         chk({name, "_wb_st"}, {9'b0, dbg_state}, {9'b0, ST_WB});
      end
      tick();
      chk({name, "_next_st"}, {9'b0, dbg_state}, {9'b0, ST_FETCH});
   endtask

   int pc0;

   initial begin
      // Reset held low across several edges: everything quiet, state FETCH.
      reset  = 1'b0;
      opCode = 3'b100;
      tick();
      tick();
      chk("rst_out", outs, O_NONE);
      chk("rst_st", {9'b0, dbg_state}, {9'b0, ST_FETCH});

      // Release: FETCH drives IREn/PCEn immediately.
      reset = 1'b1;
      #1;
      chk("rel_out", outs, O_FETCH);

      // Full instruction set, one at a time.
      run_instr("add",   3'b100, O_ADD,     1'b0);
      run_instr("load",  3'b000, O_LOAD_EX, 1'b1);
      run_instr("store", 3'b001, O_STORE,   1'b0);
      run_instr("disp",  3'b010, O_DISP,    1'b0);
      run_instr("nop",   3'b011, O_NONE,    1'b0);
      run_instr("sub",   3'b101, O_SUB,     1'b0);
      run_instr("and",   3'b110, O_AND,     1'b0);
      run_instr("or",    3'b111, O_OR,      1'b0);

      // Async reset in the middle of an ADD EXEC cycle.
      opCode = 3'b100;
      tick();  // DECODE
      tick();  // EXEC
      chk("abort_pre", outs, O_ADD);
      #2 reset = 1'b0;
      #1;
      chk("abort_out", outs, O_NONE);
      chk("abort_st", {9'b0, dbg_state}, {9'b0, ST_FETCH});
      tick();
      tick();
      chk("abort_hold", outs, O_NONE);
      reset = 1'b1;
      #1;
      chk("abort_rel", outs, O_FETCH);
      tick();
      chk("abort_dec_st", {9'b0, dbg_state}, {9'b0, ST_DECODE});
      chk("abort_dec_out", outs, O_NONE);
      tick();
      tick();  // ADD EXEC then back to FETCH
      chk("abort_fetch_st", {9'b0, dbg_state}, {9'b0, ST_FETCH});

      // Four mixed instructions back-to-back: exactly four PCEn pulses.
      pc0 = pcen_cnt;
      run_instr("mix_ld", 3'b000, O_LOAD_EX, 1'b1);
      run_instr("mix_or", 3'b111, O_OR,      1'b0);
      run_instr("mix_st", 3'b001, O_STORE,   1'b0);
      run_instr("mix_sb", 3'b101, O_SUB,     1'b0);
      chk("pcen_count", 11'(pcen_cnt - pc0), 11'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
